// File: rtl/fade_multi.sv
// Multi-channel triangular PWM fader: one shared step prescaler, and one
// rise/top/fall/bottom sequencer per channel with a per-index start stagger.
module fade_multi #(
  parameter int NUM_CH         = 3,
  parameter int STEP_INTERVAL  = 6666,
  parameter int STEPS_PER_RAMP = 300,
  parameter int PWM_INTERVAL   = 1800,
  parameter int STEP_VAL       = PWM_INTERVAL / STEPS_PER_RAMP,
  parameter int DWELL_STEPS    = 0,
  parameter int STAGGER_STEPS  = 100,
  localparam int W             = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic [NUM_CH*W-1:0] pwm_value,
  output logic [NUM_CH-1:0]   peak,
  output logic [NUM_CH-1:0]   trough
);

  localparam int PW       = $clog2(STEP_INTERVAL);
  localparam int STAG_MAX = (NUM_CH - 1) * STAGGER_STEPS;
  localparam int CMAX_A   = (STEPS_PER_RAMP > DWELL_STEPS) ? STEPS_PER_RAMP : DWELL_STEPS;
  localparam int CMAX     = (CMAX_A > STAG_MAX) ? CMAX_A : STAG_MAX;
  localparam int CW       = $clog2(CMAX + 1);

  localparam logic [W:0]    STEP_X = (W+1)'(STEP_VAL);
  localparam logic [W:0]    PWM_X  = (W+1)'(PWM_INTERVAL);
  localparam logic [W-1:0]  PWM_V  = W'(PWM_INTERVAL);
  localparam logic [CW-1:0] SPR_C  = CW'(STEPS_PER_RAMP);
  localparam logic [CW-1:0] DW_C   = CW'(DWELL_STEPS);

  typedef enum logic [2:0] {START, RISE, TOP, FALL, BOTTOM} state_e;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (enable) begin
      if (pre_q == PW'(STEP_INTERVAL - 1)) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [CW-1:0] STAG_C = CW'(k * STAGGER_STEPS);

    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d, n;
    logic [W-1:0]  val_q, val_d;
    logic          pk_q, pk_d, tr_q, tr_d;
    logic          rise_step, fall_step;
    logic [W:0]    up_sum, dn_sum;

    always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      val_d     = val_q;
      pk_d      = 1'b0;
      tr_d      = 1'b0;
      rise_step = 1'b0;
      fall_step = 1'b0;
      n         = cnt_q + 1'b1;
      up_sum    = {1'b0, val_q} + STEP_X;
      dn_sum    = {1'b0, val_q} - STEP_X;
      if (tick) begin
        unique case (st_q)
          // The tick that ends the stagger is also the first rise step.
          START: begin
            if (cnt_q == STAG_C) begin
              rise_step = 1'b1;
              n         = CW'(1);
            end else begin
              cnt_d = n;
            end
          end
          RISE: rise_step = 1'b1;
          TOP: begin
            if (n == DW_C) begin
              st_d  = FALL;
              cnt_d = '0;
            end else begin
              cnt_d = n;
            end
          end
          FALL: fall_step = 1'b1;
          BOTTOM: begin
            if (n == DW_C) begin
              st_d  = RISE;
              cnt_d = '0;
            end else begin
              cnt_d = n;
            end
          end
          default: ;
        endcase
      end
      if (rise_step) begin
        val_d = (up_sum > PWM_X) ? PWM_V : up_sum[W-1:0];
        if (n == SPR_C) begin
          pk_d  = 1'b1;
          cnt_d = '0;
          st_d  = (DWELL_STEPS == 0) ? FALL : TOP;
        end else begin
          st_d  = RISE;
          cnt_d = n;
        end
      end
      if (fall_step) begin
        val_d = ({1'b0, val_q} < STEP_X) ? '0 : dn_sum[W-1:0];
        if (n == SPR_C) begin
          tr_d  = 1'b1;
          cnt_d = '0;
          st_d  = (DWELL_STEPS == 0) ? RISE : BOTTOM;
        end else begin
          cnt_d = n;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= START;
        cnt_q <= '0;
        val_q <= '0;
        pk_q  <= 1'b0;
        tr_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        val_q <= val_d;
        pk_q  <= pk_d;
        tr_q  <= tr_d;
      end
    end

    assign pwm_value[k*W +: W] = val_q;
    assign peak[k]             = pk_q;
    assign trough[k]           = tr_q;
  end

endmodule
